dct_stream_ctrl: RTL and testbench

DCT_STREAM_CTRL -- requirements
Module: dct_stream_ctrl

---
 rtl/dct_stream_ctrl_if.sv | 28 ++
 rtl/dct_stream_ctrl.sv | 123 ++++++++++++
 tb/tb_dct_stream_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dct_stream_ctrl_if.sv
// Stream/DCT handshake bundle for dct_stream_ctrl.
// master = the controller, slave = the surrounding source/DCT/sink environment.
interface dct_stream_ctrl_if #(
  parameter int DW  = 12,
  parameter int BLK = 8
);
  logic                in_valid;
  logic [DW-1:0]       in_data;
  logic                in_ready;
  logic [BLK*DW-1:0]   samp_bus;
  logic                dct_start;
  logic                dct_done;
  logic [BLK*DW-1:0]   coef_bus;
  logic                out_valid;
  logic                out_ready;
  logic [DW-1:0]       out_data;
  logic                out_last;

  modport master (
    input  in_valid, in_data, dct_done, coef_bus, out_ready,
    output in_ready, samp_bus, dct_start, out_valid, out_data, out_last
  );

  modport slave (
    output in_valid, in_data, dct_done, coef_bus, out_ready,
    input  in_ready, samp_bus, dct_start, out_valid, out_data, out_last
  );
endinterface

// File: rtl/dct_stream_ctrl.sv
// Collects BLK samples, launches the DCT, waits (bounded) for its result and
// serializes the coefficients to the RLE stage with valid/ready handshake.
module dct_stream_ctrl #(
  parameter int DW  = 12,
  parameter int BLK = 8,
  parameter int TMO = 255
) (
  input  logic               clk,
  input  logic               reset,
  dct_stream_ctrl_if.master  bus,
  input  logic               err_clr,
  output logic               err_timeout,
  output logic [15:0]        blk_count
);
  localparam int IW = (BLK > 1) ? $clog2(BLK) : 1;
  localparam int TW = (TMO > 1) ? $clog2(TMO + 1) : 1;

  typedef enum logic [1:0] {FILL, START, WAIT, DRAIN} state_e;

  state_e                      state_q, state_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic [IW-1:0]               cnt_q, cnt_d;
  logic [TW-1:0]               tmr_q, tmr_d;
  logic                        in_ready_q, in_ready_d;
  logic [BLK-1:0][DW-1:0]      samp_q, samp_d;
  logic [BLK-1:0][DW-1:0]      coef_q, coef_d;
  logic                        err_q, err_d;
  logic [15:0]                 blk_q, blk_d;

  // Next-state: fill slots, pulse start, bounded wait for done, drain coefs.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    samp_d  = samp_q;
    coef_d  = coef_q;
    err_d   = err_q;
    blk_d   = blk_q;
    // Clear first so a timeout set further down overrides it.
    if (err_clr) err_d = 1'b0;
    case (state_q)
      FILL: begin
        if (bus.in_valid && in_ready_q) begin
          samp_d[idx_q] = bus.in_data;
          if (idx_q == IW'(BLK - 1)) begin
            idx_d   = '0;
            state_d = START;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      START: begin
        state_d = WAIT;
        tmr_d   = '0;
      end
      WAIT: begin
        if (bus.dct_done) begin
          coef_d  = bus.coef_bus;
          cnt_d   = '0;
          state_d = DRAIN;
        end else if (tmr_q == TW'(TMO - 1)) begin
          // tmr counts completed WAIT cycles; this is the TMO-th one.
          err_d   = 1'b1;
          idx_d   = '0;
          tmr_d   = '0;
          state_d = FILL;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      DRAIN: begin
        if (bus.out_ready) begin
          if (cnt_q == IW'(BLK - 1)) begin
            cnt_d   = '0;
            blk_d   = blk_q + 16'd1;
            state_d = FILL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = FILL;
    endcase
    // Registered ready: high exactly while the next state is FILL.
    in_ready_d = (state_d == FILL);
  end

  // State and datapath registers; reset discards any block in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= FILL;
      idx_q      <= '0;
      cnt_q      <= '0;
      tmr_q      <= '0;
      in_ready_q <= 1'b0;
      samp_q     <= '0;
      coef_q     <= '0;
      err_q      <= 1'b0;
      blk_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      tmr_q      <= tmr_d;
      in_ready_q <= in_ready_d;
      samp_q     <= samp_d;
      coef_q     <= coef_d;
      err_q      <= err_d;
      blk_q      <= blk_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.samp_bus  = samp_q;
  assign bus.dct_start = (state_q == START);
  assign bus.out_valid = (state_q == DRAIN);
  assign bus.out_data  = (state_q == DRAIN) ? coef_q[cnt_q] : '0;
  assign bus.out_last  = (state_q == DRAIN) && (cnt_q == IW'(BLK - 1));
  assign err_timeout   = err_q;
  assign blk_count     = blk_q;
endmodule

// File: tb/tb_dct_stream_ctrl.sv
// Randomized scoreboard bench for dct_stream_ctrl; the bench plays the sample
// source, the DCT engine and the RLE sink.
module tb_dct_stream_ctrl;
  localparam int DW  = 12;
  localparam int BLK = 8;
  localparam int TMO = 255;
  localparam int CW  = 128;

  logic        clk = 1'b0;
  logic        reset;
  logic        err_clr;
  logic        err_timeout;
  logic [15:0] blk_count;

  dct_stream_ctrl_if #(.DW(DW), .BLK(BLK)) bus();

  dct_stream_ctrl #(.DW(DW), .BLK(BLK), .TMO(TMO)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .err_clr(err_clr), .err_timeout(err_timeout), .blk_count(blk_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] d; bit last; } coef_t;

  coef_t             exp_q[$];
  logic [DW-1:0]     acc[$];
  logic [BLK*DW-1:0] held;
  bit                held_v;
  int                exp_blk;
  int                nblk;
  int                total = 0;
  int                bad   = 0;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: accepted samples form the expected block; coefficients pop from the scoreboard.
  initial forever begin : mon
    logic [BLK*DW-1:0] v;
    @(negedge clk);
    if (!reset) begin
      exp_q.delete(); acc.delete(); exp_blk = 0; held_v = 0;
    end else begin
      chk("blk_count", CW'(blk_count), CW'(exp_blk));
      if (bus.dct_start) begin
        chk("start_after_blk", CW'(acc.size()), CW'(BLK));
        v = '0;
        for (int k = 0; k < BLK && k < acc.size(); k++) v[k*DW +: DW] = acc[k];
        chk("samp_bus", CW'(bus.samp_bus), CW'(v));
        held = v; held_v = 1; acc.delete();
      end else if (held_v && !bus.in_ready) begin
        chk("samp_hold", CW'(bus.samp_bus), CW'(held));
      end
      if (bus.in_valid && bus.in_ready) acc.push_back(bus.in_data);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("out_valid_no_block", CW'(bus.out_valid), CW'(0));
        end else begin
          chk("out_data", CW'(bus.out_data), CW'(exp_q[0].d));
          chk("out_last", CW'(bus.out_last), CW'(exp_q[0].last));
          if (bus.out_ready) begin
            if (exp_q[0].last) exp_blk++;
            void'(exp_q.pop_front());
          end
        end
      end else begin
        chk("idle_out", CW'({bus.out_data, bus.out_last}), CW'(0));
      end
    end
  end

  // mode 0: always valid, 1: alternate 1/0, 2: random.
  task automatic feed(input int mode, input bit seq);
    int n = 0; int cyc = 0; bit ph = 1'b1;
    while (n < BLK && cyc < 200) begin
      @(posedge clk); #1;
      case (mode)
        0: bus.in_valid = 1'b1;
        1: begin bus.in_valid = ph; ph = !ph; end
        default: bus.in_valid = 1'($urandom_range(0, 1));
      endcase
      bus.in_data = (seq && bus.in_valid) ? DW'(n + 1) : DW'($urandom);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) n++;
      cyc++;
    end
    chk("feed_budget", CW'(n), CW'(BLK));
    @(posedge clk); #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_start(output bit ok);
    int c = 0;
    ok = 1'b0;
    while (c < 40) begin
      @(negedge clk); c++;
      if (bus.dct_start) begin ok = 1'b1; break; end
    end
    chk("dct_start_seen", CW'(ok), CW'(1));
  endtask

  task automatic set_ready(input int t, input int stall_at, input int stall_len,
                           input bit rnd, inout int stall);
    if (t == stall_at && stall < stall_len) begin
      bus.out_ready = 1'b0; stall++;
    end else begin
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  // Acts as the DCT (done after dly WAIT cycles) and as the RLE sink.
  task automatic run_block(input int dly, input bit seqc, input int stall_at,
                           input int stall_len, input bit rnd, input int abort_at);
    int t = 0; int stall = 0; int cyc = 0; coef_t e;
    repeat (dly) begin
      @(posedge clk); #1;
      if (rnd) begin bus.in_valid = 1'($urandom_range(0, 1)); bus.in_data = DW'($urandom); end
    end
    for (int k = 0; k < BLK; k++) begin
      e.d = seqc ? DW'(10 * (k + 1)) : DW'($urandom);
      e.last = (k == BLK - 1);
      exp_q.push_back(e);
      bus.coef_bus[k*DW +: DW] = e.d;
    end
    bus.dct_done = 1'b1;
    @(posedge clk); #1;
    bus.dct_done = 1'b0;
    for (int k = 0; k < BLK; k++) bus.coef_bus[k*DW +: DW] = DW'($urandom);
    set_ready(t, stall_at, stall_len, rnd, stall);
    @(negedge clk);
    chk("first_valid_latency", CW'(bus.out_valid), CW'(1));
    while (cyc < 300) begin
      if (bus.out_valid && bus.out_ready) t++;
      if (t == abort_at || t == BLK) break;
      @(posedge clk); #1;
      set_ready(t, stall_at, stall_len, rnd, stall);
      if (rnd) begin
        bus.dct_done = 1'($urandom_range(0, 1));
        for (int k = 0; k < BLK; k++) bus.coef_bus[k*DW +: DW] = DW'($urandom);
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_data  = DW'($urandom);
      end
      @(negedge clk); cyc++;
    end
    if (t == abort_at) return;
    chk("drain_count", CW'(t), CW'(BLK));
    @(posedge clk); #1;
    bus.dct_done = 1'b0; bus.out_ready = 1'b1; bus.in_valid = 1'b0;
    nblk++;
    @(negedge clk);
    chk("blk_count_after", CW'(blk_count), CW'(nblk));
    chk("back_to_fill", CW'({bus.in_ready, bus.out_valid}), CW'(2'b10));
    chk("scoreboard_empty", CW'(exp_q.size()), CW'(0));
  endtask

  task automatic timeout_run(input bit clr_held);
    bit ok; int n = 0;
    err_clr = clr_held;
    feed(0, 0);
    wait_start(ok);
    while (n < 300) begin
      @(negedge clk); n++;
      if (err_timeout) break;
    end
    chk("timeout_cycles", CW'(n), CW'(TMO + 1));
    chk("timeout_fill", CW'(bus.in_ready), CW'(1));
    chk("timeout_blk", CW'(blk_count), CW'(nblk));
  endtask

  initial begin
    bit ok;
    reset = 1'b1; err_clr = 1'b0; nblk = 0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.dct_done = 1'b0;
    bus.coef_bus = '0; bus.out_ready = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", CW'(bus.in_ready), CW'(0));
    chk("rst_outs", CW'({bus.dct_start, bus.out_valid, bus.out_last, bus.out_data}), CW'(0));
    chk("rst_samp", CW'(bus.samp_bus), CW'(0));
    chk("rst_err_blk", CW'({err_timeout, blk_count}), CW'(0));
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("in_ready_before_edge", CW'(bus.in_ready), CW'(0));
    @(negedge clk);
    chk("in_ready_after_edge", CW'(bus.in_ready), CW'(1));

    // dct_done while filling must be ignored.
    repeat (4) begin
      @(posedge clk); #1;
      bus.dct_done = 1'b1;
      for (int k = 0; k < BLK; k++) bus.coef_bus[k*DW +: DW] = DW'($urandom);
      @(negedge clk);
      chk("ign_done", CW'({bus.in_ready, bus.out_valid, bus.dct_start}), CW'(3'b100));
    end
    @(posedge clk); #1 bus.dct_done = 1'b0;

    // Basic flow: samples 1..8, coefs 10..80 after 3 cycles.
    feed(0, 1); wait_start(ok);
    if (ok) run_block(3, 1, -1, 0, 0, -1);
    // Backpressure on the third coefficient.
    feed(0, 0); wait_start(ok);
    if (ok) run_block(2, 0, 2, 4, 0, -1);
    // Input gaps.
    feed(1, 1); wait_start(ok);
    if (ok) run_block(1, 0, -1, 0, 0, -1);
    // Random traffic.
    repeat (6) begin
      feed(2, 0); wait_start(ok);
      if (ok) run_block($urandom_range(1, 10), 0, $urandom_range(0, BLK - 1),
                        $urandom_range(0, 3), 1, -1);
    end

    // Timeout, sticky flag, clear.
    timeout_run(1'b0);
    repeat (3) @(negedge clk);
    chk("err_sticky", CW'(err_timeout), CW'(1));
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    chk("err_cleared", CW'(err_timeout), CW'(0));
    // Timeout with err_clr held: the set wins, then the clear takes effect.
    timeout_run(1'b1);
    @(negedge clk);
    chk("err_clr_after_set", CW'(err_timeout), CW'(0));
    @(posedge clk); #1 err_clr = 1'b0;

    // Block after timeout starts from slot 0.
    feed(0, 1); wait_start(ok);
    if (ok) run_block(2, 1, -1, 0, 0, -1);

    // Reset during DRAIN after two transfers.
    feed(2, 0); wait_start(ok);
    if (ok) run_block(2, 0, -1, 0, 0, 2);
    @(posedge clk); #1 reset = 1'b0;
    #1;
    chk("midrst_outs", CW'({bus.dct_start, bus.out_valid, bus.out_last, bus.out_data}), CW'(0));
    chk("midrst_in_ready", CW'(bus.in_ready), CW'(0));
    chk("midrst_samp", CW'(bus.samp_bus), CW'(0));
    chk("midrst_err_blk", CW'({err_timeout, blk_count}), CW'(0));
    nblk = 0; bus.out_ready = 1'b1; bus.in_valid = 1'b0; bus.dct_done = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("rel_in_ready0", CW'(bus.in_ready), CW'(0));
    @(negedge clk);
    chk("rel_in_ready1", CW'(bus.in_ready), CW'(1));
    repeat (3) @(negedge clk);
    feed(0, 1); wait_start(ok);
    if (ok) run_block(4, 1, -1, 0, 0, -1);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
